// File: rtl/display_arbiter_if.sv
// Bundle between the three display requesters and the arbiter, plus the
// registered digit/dp/grant outputs that feed the sevensegment controller.
interface display_arbiter_if;
    logic [2:0]  req;
    logic [59:0] req_digits;
    logic [11:0] req_dp;
    logic [4:0]  d0;
    logic [4:0]  d1;
    logic [4:0]  d2;
    logic [4:0]  d3;
    logic [3:0]  dp;
    logic [2:0]  grant;
    logic        busy;

    modport master (
        output req, req_digits, req_dp,
        input  d0, d1, d2, d3, dp, grant, busy
    );

    modport slave (
        input  req, req_digits, req_dp,
        output d0, d1, d2, d3, dp, grant, busy
    );
endinterface

// File: rtl/display_arbiter.sv
// Round-robin owner of the shared 4-digit display with a minimum hold time
// per grant; blanks the display when nobody is requesting.
module display_arbiter #(
    parameter bit simulate = 1'b0
) (
    input logic             clk,
    input logic             reset,
    display_arbiter_if.slave bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [25:0] HOLD_CNT = simulate ? 26'd5 : 26'd50_000_000;
    localparam logic [4:0]  BLANK    = 5'd23;

    state_t      state;
    logic [1:0]  last;
    logic [25:0] cnt;
    logic [2:0]  grant;
    logic [19:0] disp;
    logic [3:0]  disp_dp;

    logic [2:0]  others;
    logic [1:0]  win;
    logic [19:0] win_digits;
    logic [3:0]  win_dp;
    logic [19:0] own_digits;
    logic [3:0]  own_dp;

    function automatic logic [1:0] inc3(input logic [1:0] x);
        inc3 = (x == 2'd2) ? 2'd0 : x + 2'd1;
    endfunction

    // Later assignments override earlier ones, so the candidate right after
    // 'from' ends up with the highest priority.
    function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] from);
        logic [1:0] c1, c2, c3;
        c1 = inc3(from);
        c2 = inc3(c1);
        c3 = inc3(c2);
        rr_pick = c3;
        if (mask[c2]) rr_pick = c2;
        if (mask[c1]) rr_pick = c1;
    endfunction

    function automatic logic [19:0] digit_slice(input logic [59:0] all, input logic [1:0] i);
        case (i)
            2'd0:    digit_slice = all[19:0];
            2'd1:    digit_slice = all[39:20];
            default: digit_slice = all[59:40];
        endcase
    endfunction

    function automatic logic [3:0] dp_slice(input logic [11:0] all, input logic [1:0] i);
        case (i)
            2'd0:    dp_slice = all[3:0];
            2'd1:    dp_slice = all[7:4];
            default: dp_slice = all[11:8];
        endcase
    endfunction

    // In IDLE grant is zero, so 'others' is simply the full request vector.
    always_comb begin
        others     = bus.req & ~grant;
        win        = rr_pick(others, last);
        win_digits = digit_slice(bus.req_digits, win);
        win_dp     = dp_slice(bus.req_dp, win);
        own_digits = digit_slice(bus.req_digits, last);
        own_dp     = dp_slice(bus.req_dp, last);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 2'd2;
            cnt     <= '0;
            grant   <= '0;
            disp    <= {BLANK, BLANK, BLANK, BLANK};
            disp_dp <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state   <= HOLD;
                        grant   <= 3'b001 << win;
                        last    <= win;
                        cnt     <= '0;
                        disp    <= win_digits;
                        disp_dp <= win_dp;
                    end
                end
                HOLD: begin
                    if (cnt != HOLD_CNT) begin
                        cnt <= cnt + 26'd1;
                        if (bus.req[last]) begin
                            disp    <= own_digits;
                            disp_dp <= own_dp;
                        end
                    end else if (|others) begin
                        grant   <= 3'b001 << win;
                        last    <= win;
                        cnt     <= '0;
                        disp    <= win_digits;
                        disp_dp <= win_dp;
                    end else if (bus.req[last]) begin
                        disp    <= own_digits;
                        disp_dp <= own_dp;
                    end else begin
                        state   <= IDLE;
                        grant   <= '0;
                        disp    <= {BLANK, BLANK, BLANK, BLANK};
                        disp_dp <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant;
    assign bus.busy  = |grant;
    assign bus.d0    = disp[4:0];
    assign bus.d1    = disp[9:5];
    assign bus.d2    = disp[14:10];
    assign bus.d3    = disp[19:15];
    assign bus.dp    = disp_dp;
endmodule

// File: doc/display_arbiter.md
# display_arbiter

Shares the single 4-digit 7-segment display between three independent requesters (for example game status, score and debug readout). It grants the display using round-robin arbitration, enforces a minimum on-screen hold time per grant, and drives the `d0`–`d3` / `dp` inputs of the `sevensegment` controller. When no requester is active it blanks the display.

## Interface
- `simulate`, default 0: selects the hold count. 0 gives `hold_cnt` = 26'd50_000_000 (0.5 s at 100 MHz). 1 gives `hold_cnt` = 26'd5.
- `clk`  in  1  100 MHz system clock. Single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  3  request per requester; bit i belongs to requester i.
- `req_digits`  in  60  packed digit codes. Requester i uses bits [20i+19:20i], which split into digit3..digit0 at 5 bits each (digit0 is the LSBs).
- `req_dp`  in  12  packed decimal points. Requester i uses bits [4i+3:4i].
- `d0`, `d1`, `d2`, `d3`  out  5 each  digit codes to `sevensegment` (registered).
- `dp`  out  4  decimal points to `sevensegment` (registered).
- `grant`  out  3  one-hot owner of the display; 000 when idle (registered).
- `busy`  out  1  high whenever `grant` != 000.

## Operation
- States: IDLE, HOLD.
- Round-robin pointer `last` (2 bits) holds the index of the most recent grantee.
  - Search order starts at `last`+1 and wraps modulo 3.
  - Reset value of `last` is 2, so requester 0 has first priority after reset.
- Hold counter: 26 bits, cleared on every new grant. It increments each cycle in HOLD and saturates at `hold_cnt`.
- IDLE:
  - `grant` = 000, `d0`–`d3` = 23 (blank), `dp` = 0000.
  - If `req` != 0: select the winner by round-robin, set `grant` to that one-hot value, load `last`, clear the counter, and go to HOLD.
- HOLD, counter < `hold_cnt` (minimum hold period):
  - No preemption. `grant` is unchanged.
  - While `req[g]` = 1, the outputs copy the grantee's `req_digits` and `req_dp` slice every cycle.
  - While `req[g]` = 0 (dropped early), the outputs freeze at the last copied values.
- HOLD, counter == `hold_cnt` (arbitration point), evaluated every cycle while saturated:
  - Another requester active: round-robin winner (which excludes the current owner first), new `grant`, counter cleared, copy continues from the new owner.
  - Only the current owner active: keep the grant and keep the counter saturated. A new request arriving later is granted at the next edge.
  - No request active: go to IDLE. The outputs blank at the same edge.
- Simultaneous requests: only the round-robin order decides the winner; there is no fixed priority.
- Reset has priority over everything, including mid-HOLD. After reset: IDLE, `grant` = 000, `busy` = 0, `d0`–`d3` = 23, `dp` = 0, counter = 0, `last` = 2.
- Digit codes are passed through unchanged; no range checking is done.

## Timing
- All outputs are registered.
- Request-to-grant latency: `req` sampled high at edge N in IDLE gives `grant` valid after edge N.
- Digit latency: grantee inputs sampled at edge N appear on `d0`–`d3` / `dp` after edge N. These values are first valid in the same cycle that `grant` first shows the new owner.
- A grant lasts at least `hold_cnt`+1 cycles: 6 cycles with `simulate` = 1.
- Handover is seamless: the old owner's last values are followed directly by the new owner's values, with no blank cycle between them.
- `busy` is `|grant`, taken from the registered grant, so it has zero added latency.

## Test plan
- Reset check (`simulate` = 1): assert `reset` for 2 cycles with all `req` = 111. Required: `grant` = 000, `d0`–`d3` = 23, `dp` = 0 while reset is high. On the first edge after release, `grant` = 001.
- Single requester: `req` = 010, slice 1 digits {3,2,1,0}, dp 0101. Required: one cycle later `grant` = 010, `d3..d0` = 3,2,1,0, `dp` = 0101. Change the slice mid-hold to {9,9,9,9}; the outputs follow one cycle later.
- Rotation: `req` = 101 held continuously after reset. Required: `grant` sequence 001 for 6 cycles, then 100 for 6 cycles, then 001, with no idle gap.
- Early drop: requester 1 granted, `req[1]` deasserted 2 cycles into the hold. Required: outputs frozen, `grant` = 010 until the counter reaches 5, then the next edge gives `grant` = 000 and `d` = 23.
- Saturated owner: `req` = 001 held for 20 cycles. Required: `grant` = 001 throughout. Raise `req[2]` at cycle 20; `grant` = 100 on the next edge.
- Reset mid-hold: assert `reset` 3 cycles into a requester-2 grant. Required: idle values next edge and `last` = 2. With `req` = 111 after release, `grant` = 001.
